muldiv_unit: RTL
================

# muldiv_unit

- Iterative, parametrised multiply/divide unit that owns the HI/LO register pair.
- Successor to the single-cycle combinational mult/div path: a signed/unsigned N-bit operation runs over N+1 cycles with a start/busy/done handshake, so the core's critical path no longer contains an N×N multiplier or divider.
- Sits beside the ALU in the execute stage. The pipeline stalls on `busy` and reads `hi`/`lo` for mfhi/mflo.

## Interface
- `N`, default 32: operand width; `hi` and `lo` are each N bits. Legal range is 8..64.
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `start`, in, 1: request; sampled only while idle.
- `op`, in, 3: operation select.
  - 000 mult
  - 001 multu
  - 010 div
  - 011 divu
  - 100 mthi
  - 101 mtlo
  - 110 and 111 are no-ops.
- `a`, in, N: multiplicand/dividend, or the mthi/mtlo source.
- `b`, in, N: multiplier/divisor.
- `cancel`, in, 1: abort the current operation (exception flush).
- `busy`, out, 1: operation in progress; new starts are ignored.
- `done`, out, 1: one-cycle pulse after `hi`/`lo` are updated by mult/div.
- `hi`, out, N: HI register (product upper half, or remainder).
- `lo`, out, N: LO register (product lower half, or quotient).

## Operation
- States:
  - IDLE
  - CALC, with an iteration counter of width clog2(N+1)
  - FIX
- Reset (async, `rst_n`=0): state=IDLE, `hi`=0, `lo`=0, `busy`=0, `done`=0, counter=0.
- IDLE, `start`=1 and `cancel`=0:
  - op 000..011: latch `a`, `b`, `op`. For signed ops latch operand magnitudes and result sign flags; for unsigned ops latch the raw values. Go to CALC with counter=0.
  - op 100: `hi`<=`a` at this edge; stay IDLE; no `done`.
  - op 101: `lo`<=`a` at this edge; stay IDLE; no `done`.
  - op 110/111: ignored.
- CALC, multiply:
  - Radix-2 shift-add over the 2N-bit {acc, multiplier} register.
  - One bit per cycle, N cycles.
- CALC, divide:
  - Restoring division of the magnitudes.
  - One quotient bit per cycle, N cycles.
  - The partial remainder is N+1 bits wide so the subtract never loses its borrow.
- FIX (one cycle):
  - Apply the sign correction.
  - Write `hi`/`lo`.
  - Return to IDLE.
- Arithmetic rules:
  - mult: {hi,lo} = signed a × signed b, full 2N bits.
  - multu: {hi,lo} = unsigned a × unsigned b, full 2N bits.
  - div/divu: lo = quotient truncated toward zero; hi = remainder. The remainder takes the sign of the dividend (signed only).
  - Divide by zero (div and divu): lo = all ones, hi = a. Latency is unchanged.
  - Signed overflow (most negative value / −1): lo = most negative value, hi = 0. This falls out naturally from the magnitude method and needs no special case.
- `cancel`=1 in any state: next state is IDLE; `hi`/`lo` are unchanged; no `done` pulse.
  - `cancel` together with `start` in IDLE: cancel wins, and nothing starts (mthi/mtlo included).
- `start` while `busy`=1 is ignored.
- Changes on `a`/`b`/`op` after the start cycle have no effect.
- Reset asserted mid-operation aborts immediately. All outputs go to their reset values.

## Timing
- Let cycle 0 be the cycle in which `start`=1 is sampled in IDLE.
- `busy`=1 in cycles 1..N+1; the last of these is FIX.
- `hi`/`lo` are updated at the end of cycle N+1.
- `done`=1 in cycle N+2 only. In that cycle `busy`=0 and the new `hi`/`lo` are visible.
- Total latency is N+2 cycles from start to `done`. It is independent of operand values, zero divisor and signedness.
- Back-to-back: a `start` in cycle N+2 is accepted, and `done` from the previous op still pulses in that cycle.
- mthi/mtlo: the new value is visible in cycle 1. `busy` is never raised.
- `busy` and `done` are registered outputs with no combinational path from inputs.

## Test plan
- Reset, N=32: assert `rst_n`=0 for 2 cycles, then release.
  - Required: `hi`=`lo`=0, `busy`=`done`=0.
  - Then mthi a=0x12345678 → `hi`=0x12345678 in cycle 1, `busy` stays 0.
- mult a=0xFFFFFFFD (−3), b=5.
  - Required: `done` in cycle 34; `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1.
- multu a=b=0xFFFFFFFF.
  - Required: `hi`=0xFFFFFFFE, `lo`=0x00000001.
  - Issue a second start (divu 100/7) in the `done` cycle.
  - Required: the second op completes 34 cycles later with `lo`=14, `hi`=2.
- div a=0xFFFFFFF9 (−7), b=2.
  - Required: `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- div a=0x80000000, b=0xFFFFFFFF.
  - Required: `lo`=0x80000000, `hi`=0.
- divu a=7, b=0.
  - Required: `lo`=0xFFFFFFFF, `hi`=7, same latency.
- Abort paths, starting from `hi`=0xA, `lo`=0xB:
  - Start div, pulse `cancel` in cycle 5. Required: `busy`=0 from cycle 6, no `done`, `hi`=0xA and `lo`=0xB unchanged.
  - Start a new op, then assert `rst_n`=0 at cycle 10. Required: all outputs read 0 immediately.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Core-side handshake bundle for the iterative multiply/divide unit.
// The core drives the request fields and reads back status and HI/LO.
interface muldiv_unit_if #(parameter int N = 32);
  logic         start;
  logic [2:0]   op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cancel;
  logic         busy;
  logic         done;
  logic [N-1:0] hi;
  logic [N-1:0] lo;

  modport master (output start, op, a, b, cancel, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, cancel, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply/divide that owns HI/LO.
// The operation runs on operand magnitudes for N cycles, then a FIX cycle applies signs.
module muldiv_unit #(
  parameter int N = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  muldiv_unit_if.slave  bus
);
  localparam int CW = $clog2(N+1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [N:0]    acc;     // product high half / partial remainder
  logic [N-1:0]  sreg;    // multiplier / dividend shifting into quotient
  logic [N-1:0]  opnd;    // multiplicand / divisor magnitude
  logic          is_div, neg_lo, neg_hi, dz;
  logic [N-1:0]  hi_q, lo_q;
  logic          busy_q, done_q;

  // Operand preparation: op[0]=0 selects the signed variants of mult/div.
  logic         sa, sb;
  logic [N-1:0] mag_a, mag_b;
  always_comb begin
    sa    = bus.a[N-1] & ~bus.op[0];
    sb    = bus.b[N-1] & ~bus.op[0];
    mag_a = sa ? (~bus.a + 1'b1) : bus.a;
    mag_b = sb ? (~bus.b + 1'b1) : bus.b;
  end

  // One iteration of shift-add or restoring division.
  logic [N:0]   sum, msel, shifted;
  logic [N+1:0] diff;
  logic [N:0]   acc_nxt;
  logic [N-1:0] sreg_nxt;
  always_comb begin
    sum      = acc + {1'b0, opnd};
    msel     = sreg[0] ? sum : acc;
    shifted  = {acc[N-1:0], sreg[N-1]};
    diff     = {1'b0, shifted} - {2'b0, opnd};
    acc_nxt  = {1'b0, msel[N:1]};
    sreg_nxt = {msel[0], sreg[N-1:1]};
    if (is_div) begin
      if (!diff[N+1]) begin
        acc_nxt  = diff[N:0];
        sreg_nxt = {sreg[N-2:0], 1'b1};
      end else begin
        acc_nxt  = shifted;
        sreg_nxt = {sreg[N-2:0], 1'b0};
      end
    end
  end

  // Sign correction applied in FIX.
  logic [2*N-1:0] prod, prod_s;
  logic [N-1:0]   quo, rem;
  always_comb begin
    prod   = {acc[N-1:0], sreg};
    prod_s = neg_lo ? (~prod + 1'b1) : prod;
    quo    = neg_lo ? (~sreg + 1'b1) : sreg;
    rem    = neg_hi ? (~acc[N-1:0] + 1'b1) : acc[N-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      sreg   <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      dz     <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.cancel) begin
        state  <= IDLE;
        busy_q <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              case (bus.op)
                3'b000, 3'b001, 3'b010, 3'b011: begin
                  state  <= CALC;
                  busy_q <= 1'b1;
                  cnt    <= '0;
                  acc    <= '0;
                  sreg   <= mag_a;
                  opnd   <= mag_b;
                  is_div <= bus.op[1];
                  neg_lo <= sa ^ sb;
                  neg_hi <= bus.op[1] ? sa : (sa ^ sb);
                  dz     <= (bus.b == '0);
                end
                3'b100:  hi_q <= bus.a;
                3'b101:  lo_q <= bus.a;
                default: ;
              endcase
            end
          end
          CALC: begin
            acc  <= acc_nxt;
            sreg <= sreg_nxt;
            cnt  <= cnt + 1'b1;
            if (cnt == CW'(N-1)) state <= FIX;
          end
          FIX: begin
            // Zero divisor leaves |a| as remainder, so only LO needs forcing.
            if (is_div) begin
              hi_q <= rem;
              lo_q <= dz ? '1 : quo;
            end else begin
              hi_q <= prod_s[2*N-1:N];
              lo_q <= prod_s[N-1:0];
            end
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule
